// File: rtl/mult_booth_if.sv
// =============================================================================
// mult_booth_if : operand/product bundle for the sign-magnitude Booth multiplier
// Rev 1.0
// =============================================================================
`default_nettype none

interface mult_booth_if;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] P;

  modport master (output A, output B, input P);
  modport slave  (input A, input B, output P);
endinterface

`default_nettype wire

// File: rtl/mult_booth.sv
// =============================================================================
// mult_booth : Q3.12 sign-magnitude x Q3.12 -> Q7.24 two's-complement product,
//              radix-4 Booth magnitude core, one registered cycle of latency.
// Rev 1.0
// =============================================================================
`default_nettype none

module mult_booth (
  input  wire          clk,
  input  wire          rst_n,
  mult_booth_if.slave  bus
);

  logic        sgn;
  logic [14:0] ma;
  logic [14:0] mb;
  logic [16:0] rec;
  logic [2:0]  trip;
  logic [16:0] pp;
  logic [31:0] mag_sum;
  logic [31:0] p_d;
  logic [31:0] p_q;

  assign sgn = bus.A[15] ^ bus.B[15];
  assign ma  = bus.A[14:0];
  assign mb  = bus.B[14:0];
  // mb zero-extended to 16 bits with the implicit 0 below the LSB
  assign rec = {1'b0, mb, 1'b0};

  always_comb begin
    mag_sum = '0;
    trip    = '0;
    pp      = '0;
    for (int i = 0; i < 8; i++) begin
      trip = rec[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = {2'b00, ma};
        3'b011:         pp = {1'b0, ma, 1'b0};
        3'b100:         pp = -{1'b0, ma, 1'b0};
        3'b101, 3'b110: pp = -{2'b00, ma};
        default:        pp = '0;
      endcase
      mag_sum = mag_sum + ({{15{pp[16]}}, pp} << (2 * i));
    end
  end

  // The top digit is never negative, so mag_sum is ma*mb and bits 31:30 stay 0.
  // A zero magnitude negates to zero, which rules out a negative-zero result.
  always_comb begin
    p_d = sgn ? (32'd0 - mag_sum) : mag_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign bus.P = p_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_booth.sv
// =============================================================================
// tb_mult_booth : directed and reference-model checks for mult_booth
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_mult_booth;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  mult_booth_if bus ();

  mult_booth u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_p(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] m;
    m = {17'd0, a[14:0]} * {17'd0, b[14:0]};
    return (a[15] ^ b[15]) ? (32'd0 - m) : m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.A = 16'h3300;
    bus.B = 16'h2300;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.P !== 32'h0) $display("FAIL reset_hold: got %h want %h", bus.P, 32'h0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.P !== 32'h0) $display("FAIL reset_release: got %h want %h", bus.P, 32'h0);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (bus.P !== 32'h06F9_0000) $display("FAIL reset_first_edge: got %h want %h", bus.P, 32'h06F9_0000);
    else passed++;
  endtask

  task automatic test_directed();
    logic [15:0] va [10];
    logic [15:0] vb [10];
    logic [31:0] vp [10];
    va[0] = 16'h3300; vb[0] = 16'h2300; vp[0] = 32'h06F9_0000;
    va[1] = 16'h0300; vb[1] = 16'h8300; vp[1] = 32'hFFF7_0000;
    va[2] = 16'h3300; vb[2] = 16'hA300; vp[2] = 32'hF907_0000;
    va[3] = 16'hB300; vb[3] = 16'h2300; vp[3] = 32'hF907_0000;
    va[4] = 16'hB300; vb[4] = 16'hA300; vp[4] = 32'h06F9_0000;
    va[5] = 16'h7FFF; vb[5] = 16'hFFFF; vp[5] = 32'hC000_FFFF;
    va[6] = 16'h7FFF; vb[6] = 16'h7FFF; vp[6] = 32'h3FFF_0001;
    va[7] = 16'h8000; vb[7] = 16'h7FFF; vp[7] = 32'h0000_0000;
    va[8] = 16'h1234; vb[8] = 16'h8000; vp[8] = 32'h0000_0000;
    va[9] = 16'h1000; vb[9] = 16'h9000; vp[9] = 32'hFF00_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.A = va[i];
      bus.B = vb[i];
      @(posedge clk);
      #1;
      total++;
      if (bus.P !== vp[i])
        $display("FAIL directed_%0d A=%h B=%h: got %h want %h", i, va[i], vb[i], bus.P, vp[i]);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.A = 16'h7FFF;
    bus.B = 16'h7FFF;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.P !== 32'h0) $display("FAIL async_reset_immediate: got %h want %h", bus.P, 32'h0);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (bus.P !== 32'h0) $display("FAIL async_reset_held_over_edge: got %h want %h", bus.P, 32'h0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.A = 16'h0300;
    bus.B = 16'h8300;
    @(posedge clk);
    #1;
    total++;
    if (bus.P !== 32'hFFF7_0000) $display("FAIL async_reset_resume: got %h want %h", bus.P, 32'hFFF7_0000);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_p;
    int          errs;
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 50 == 0) a[14:0] = 15'd0;
      if (i % 70 == 1) b[14:0] = 15'h7FFF;
      bus.A = a;
      bus.B = b;
      exp_p = ref_p(a, b);
      @(posedge clk);
      #1;
      total++;
      if (bus.P !== exp_p) begin
        if (errs < 10)
          $display("FAIL random_%0d A=%h B=%h: got %h want %h", i, a, b, bus.P, exp_p);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b1;
    bus.A  = '0;
    bus.B  = '0;
    #2;
    test_reset();
    test_directed();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
